// File: rtl/mul16_vedic_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 16x16 Vedic multiplier controller.
package mul16_vedic_seq_ctrl_pkg;

  localparam int unsigned HALF_W = 8;

  // Left-shift applied to each 16-bit partial product before accumulation
  localparam int unsigned SH_LL  = 0;
  localparam int unsigned SH_MID = 8;
  localparam int unsigned SH_HH  = 16;

  typedef enum logic [3:0] {
    StIdle,
    StLl,
    StLh,
    StHl,
    StHh,
    StWLl,
    StWLh,
    StWHl,
    StWHh,
    StDone
  } step_state_e;

  // Which operand halves feed the shared multiplier
  typedef enum logic [1:0] {
    SelLl,
    SelLh,
    SelHl,
    SelHh
  } step_sel_e;

endpackage

// File: rtl/bk_add32.sv
// 32-bit Brent-Kung prefix adder, modulo 2^32 (no carry out).
module bk_add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] s_o
);

  logic [31:0] x;
  logic [30:0] gg, pp;

  assign x = a_i ^ b_i;

  // Up-sweep builds power-of-two group terms, down-sweep fills the remaining carries.
  // Bit 31 generate is never needed since the carry out is discarded.
  always_comb begin
    gg = a_i[30:0] & b_i[30:0];
    pp = x[30:0];
    for (int l = 0; l < 5; l++) begin
      for (int i = 0; i < 31; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    for (int l = 3; l >= 0; l--) begin
      for (int i = 0; i < 31; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        end
      end
    end
  end

  assign s_o = x ^ {gg, 1'b0};

endmodule

// File: rtl/mul16_step_fsm.sv
// Step sequencer: walks LL, LH, HL, HH (with optional wait states) and decodes datapath controls.
module mul16_step_fsm
  import mul16_vedic_seq_ctrl_pkg::*;
#(
  parameter bit PpReg = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  output logic       accept_o,
  output logic       mux_en_o,
  output step_sel_e  sel_o,
  output logic [4:0] shift_o,
  output logic       acc_en_o,
  output logic       last_o,
  output logic       busy_o,
  output logic       done_o
);

  step_state_e state_q, state_d;

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next state and control decode; W states reuse the select of their S step
  always_comb begin
    state_d  = state_q;
    accept_o = 1'b0;
    mux_en_o = 1'b0;
    sel_o    = SelLl;
    acc_en_o = 1'b0;
    last_o   = 1'b0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          accept_o = 1'b1;
          state_d  = StLl;
        end
      end
      StLl, StWLl: begin
        busy_o   = 1'b1;
        mux_en_o = 1'b1;
        sel_o    = SelLl;
        acc_en_o = !PpReg || (state_q == StWLl);
        state_d  = (PpReg && state_q == StLl) ? StWLl : StLh;
      end
      StLh, StWLh: begin
        busy_o   = 1'b1;
        mux_en_o = 1'b1;
        sel_o    = SelLh;
        acc_en_o = !PpReg || (state_q == StWLh);
        state_d  = (PpReg && state_q == StLh) ? StWLh : StHl;
      end
      StHl, StWHl: begin
        busy_o   = 1'b1;
        mux_en_o = 1'b1;
        sel_o    = SelHl;
        acc_en_o = !PpReg || (state_q == StWHl);
        state_d  = (PpReg && state_q == StHl) ? StWHl : StHh;
      end
      StHh, StWHh: begin
        busy_o   = 1'b1;
        mux_en_o = 1'b1;
        sel_o    = SelHh;
        acc_en_o = !PpReg || (state_q == StWHh);
        last_o   = acc_en_o;
        state_d  = (PpReg && state_q == StHh) ? StWHh : StDone;
      end
      StDone: begin
        done_o = 1'b1;
        if (start_i) begin
          accept_o = 1'b1;
          state_d  = StLl;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Partial-product weight for the selected step
  always_comb begin
    shift_o = 5'(SH_LL);
    unique case (sel_o)
      SelLl:        shift_o = 5'(SH_LL);
      SelLh, SelHl: shift_o = 5'(SH_MID);
      SelHh:        shift_o = 5'(SH_HH);
      default:      shift_o = 5'(SH_LL);
    endcase
  end

endmodule

// File: rtl/vedic_mul8.sv
// 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built from four 4x4 cross products.
module vedic_mul8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [7:0] q_ll, q_lh, q_hl, q_hh;

  assign q_ll = {4'b0, a_i[3:0]} * {4'b0, b_i[3:0]};
  assign q_lh = {4'b0, a_i[3:0]} * {4'b0, b_i[7:4]};
  assign q_hl = {4'b0, a_i[7:4]} * {4'b0, b_i[3:0]};
  assign q_hh = {4'b0, a_i[7:4]} * {4'b0, b_i[7:4]};

  assign p_o = {8'b0, q_ll} + {4'b0, q_lh, 4'b0} + {4'b0, q_hl, 4'b0} + {q_hh, 8'b0};

endmodule

// File: rtl/mul16_vedic_seq_ctrl.sv
// 16x16 unsigned multiplier sequenced over one shared 8x8 Vedic core and a 32-bit accumulator.
module mul16_vedic_seq_ctrl
  import mul16_vedic_seq_ctrl_pkg::*;
#(
  parameter bit          PP_REG = 1'b0,
  parameter int unsigned HALF_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2*HALF_W-1:0]   a,
  input  logic [2*HALF_W-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*HALF_W-1:0]   p
);

  logic [2*HALF_W-1:0] a_q, b_q;
  logic [4*HALF_W-1:0] acc_q, p_q, addend, sum;
  logic [HALF_W-1:0]   op_x, op_y;
  logic [2*HALF_W-1:0] pp_raw, pp_use;
  logic                accept, mux_en, acc_en, last;
  step_sel_e           sel;
  logic [4:0]          shift;

  mul16_step_fsm #(
    .PpReg (PP_REG)
  ) u_fsm (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start),
    .accept_o (accept),
    .mux_en_o (mux_en),
    .sel_o    (sel),
    .shift_o  (shift),
    .acc_en_o (acc_en),
    .last_o   (last),
    .busy_o   (busy),
    .done_o   (done)
  );

  // Operand halves for the shared multiplier; zero when idle to keep the datapath quiet
  always_comb begin
    op_x = '0;
    op_y = '0;
    if (mux_en) begin
      unique case (sel)
        SelLl: begin op_x = a_q[HALF_W-1:0];        op_y = b_q[HALF_W-1:0];        end
        SelLh: begin op_x = a_q[HALF_W-1:0];        op_y = b_q[2*HALF_W-1:HALF_W]; end
        SelHl: begin op_x = a_q[2*HALF_W-1:HALF_W]; op_y = b_q[HALF_W-1:0];        end
        SelHh: begin op_x = a_q[2*HALF_W-1:HALF_W]; op_y = b_q[2*HALF_W-1:HALF_W]; end
        default: begin op_x = '0; op_y = '0; end
      endcase
    end
  end

  vedic_mul8 u_mul (
    .a_i (op_x),
    .b_i (op_y),
    .p_o (pp_raw)
  );

  if (PP_REG) begin : g_pp_reg
    logic [2*HALF_W-1:0] pp_q;

    // Pipeline the partial product; the W state consumes it
    always_ff @(posedge clk) begin
      if (!rst_n) pp_q <= '0;
      else        pp_q <= pp_raw;
    end

    assign pp_use = pp_q;
  end else begin : g_pp_comb
    assign pp_use = pp_raw;
  end

  assign addend = {{(2*HALF_W){1'b0}}, pp_use} << shift;

  bk_add32 u_add (
    .a_i (acc_q),
    .b_i (addend),
    .s_o (sum)
  );

  // Operand latch, accumulator and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      p_q   <= '0;
    end else begin
      if (accept) begin
        a_q   <= a;
        b_q   <= b;
        acc_q <= '0;
      end else if (acc_en) begin
        acc_q <= sum;
      end
      if (last) p_q <= sum;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_mul16_vedic_seq_ctrl.sv
// Directed and random checks of mul16_vedic_seq_ctrl with PP_REG=0 (dut0) and PP_REG=1 (dut1).
module tb_mul16_vedic_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] p0, p1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul16_vedic_seq_ctrl #(.PP_REG(1'b0), .HALF_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a), .b(b),
    .busy(busy0), .done(done0), .p(p0)
  );

  mul16_vedic_seq_ctrl #(.PP_REG(1'b1), .HALF_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b),
    .busy(busy1), .done(done1), .p(p1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input bit which);
    return which ? done1 : done0;
  endfunction

  function automatic logic sel_busy(input bit which);
    return which ? busy1 : busy0;
  endfunction

  // Call just after a posedge; returns at the negedge of the done cycle or on timeout
  task automatic wait_done(input bit which, input int limit, output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      if (sel_done(which)) break;
      if (sel_busy(which)) bcnt++;
      if (n >= limit) begin
        check("done_seen", {31'b0, sel_done(which)}, 32'd1);
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Call mid-cycle; start is presented in the current cycle
  task automatic do_op(input bit which, input logic [15:0] aa, input logic [15:0] bb,
                       output int lat, output int bcnt);
    int n;
    a = aa;
    b = bb;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    wait_done(which, 20, n, bcnt);
    lat = n + 1;
  endtask

  // p may only move on DONE entry, and done never lasts two cycles
  logic [31:0] p0_prev, p1_prev;
  logic        d0_prev, d1_prev;
  always @(negedge clk) begin
    if (rst_n) begin
      if (p0 !== p0_prev) check("p0_change_outside_done", {31'b0, done0}, 32'd1);
      if (p1 !== p1_prev) check("p1_change_outside_done", {31'b0, done1}, 32'd1);
      if (done0) check("done0_width", {31'b0, d0_prev}, 32'd0);
      if (done1) check("done1_width", {31'b0, d1_prev}, 32'd0);
    end
    p0_prev <= p0;
    p1_prev <= p1;
    d0_prev <= done0;
    d1_prev <= done1;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bc, n, nd;
    logic [15:0] ra, rb;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy0", {31'b0, busy0}, 32'd0);
    check("rst_done0", {31'b0, done0}, 32'd0);
    check("rst_p0", p0, 32'd0);
    check("rst_p1", p1, 32'd0);
    check("rst_busy1", {31'b0, busy1}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic product, PP_REG=0
    do_op(1'b0, 16'h1234, 16'h5678, lat, bc);
    check("basic_p", p0, 32'h06260060);
    check("basic_lat", lat, 32'd5);
    check("basic_busy_cycles", bc, 32'd4);
    check("basic_busy_in_done", {31'b0, busy0}, 32'd0);

    // Maximum operands, PP_REG=1
    @(posedge clk); #1;
    do_op(1'b1, 16'hFFFF, 16'hFFFF, lat, bc);
    check("max_p", p1, 32'hFFFE0001);
    check("max_lat", lat, 32'd9);
    check("max_busy_cycles", bc, 32'd8);

    // Zero operand then back-to-back start in the DONE cycle
    @(posedge clk); #1;
    do_op(1'b0, 16'h0000, 16'hBEEF, lat, bc);
    check("zero_p", p0, 32'h00000000);
    do_op(1'b0, 16'h0100, 16'h0100, lat, bc);
    check("b2b_p", p0, 32'h00010000);
    check("b2b_lat", lat, 32'd5);
    check("b2b_busy_cycles", bc, 32'd4);

    // Start while busy is ignored
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0005; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done(1'b0, 20, n, bc);
    check("busy_start_p", p0, 32'h0000000F);
    check("busy_start_lat_rest", n, 32'd2);
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done0) nd++;
    end
    check("busy_start_single_done", nd, 32'd0);

    // Reset mid-operation in S_HL
    a = 16'h1234; b = 16'h5678; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_busy_before", {31'b0, busy0}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_busy", {31'b0, busy0}, 32'd0);
    check("midrst_done", {31'b0, done0}, 32'd0);
    check("midrst_p", p0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (done0) nd++;
    end
    check("midrst_no_done", nd, 32'd0);
    do_op(1'b0, 16'h00FF, 16'h00FF, lat, bc);
    check("midrst_after_p", p0, 32'h0000FE01);
    check("midrst_after_lat", lat, 32'd5);

    // Random pairs on both configurations
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 7 == 0) ra = 16'hFFFF;
      if (i % 11 == 0) rb = 16'h0000;
      do_op(1'b0, ra, rb, lat, bc);
      check("rand_p0", p0, {16'b0, ra} * {16'b0, rb});
      check("rand_lat0", lat, 32'd5);
      do_op(1'b1, rb, ra, lat, bc);
      check("rand_p1", p1, {16'b0, rb} * {16'b0, ra});
      check("rand_lat1", lat, 32'd9);
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
